// File: rtl/display_pkg.sv
// Shared types and default colours for the display layer compositor.
package display_pkg;

  localparam int DEFAULT_PIXEL_WIDTH = 24;

  typedef logic [DEFAULT_PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    FLASHING = 1'b1
  } flash_state_e;

  localparam pixel_t DEFAULT_TRANSPARENT_KEY = 24'h000000;
  localparam pixel_t DEFAULT_BG_COLOR        = 24'h000000;
  localparam pixel_t DEFAULT_BORDER_COLOR    = 24'hFFFFFF;

endpackage

// File: rtl/layer_flash_ctrl.sv
// Per-layer flash sequencer: on request, blinks the layer for FLASH_FRAMES
// frames, toggling visibility every BLINK_PERIOD frames.
module layer_flash_ctrl
  import display_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_PERIOD = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic flash_req_in,
  input  logic new_frame_in,
  output logic visible_out,
  output logic flashing_out
);

  localparam int FRAME_W = $clog2(FLASH_FRAMES + 1);
  localparam int PHASE_W = $clog2(BLINK_PERIOD + 1);

  flash_state_e       state;
  logic [FRAME_W-1:0] frames_left;
  logic [PHASE_W-1:0] phase_cnt;
  logic               hidden;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      frames_left  <= '0;
      phase_cnt    <= '0;
      hidden       <= 1'b0;
      flashing_out <= 1'b0;
    end else if (flash_req_in) begin
      // A request always (re)starts the sequence, even alongside a frame pulse.
      state        <= FLASHING;
      frames_left  <= FRAME_W'(FLASH_FRAMES);
      phase_cnt    <= '0;
      hidden       <= 1'b0;
      flashing_out <= 1'b1;
    end else if (state == FLASHING && new_frame_in) begin
      if (frames_left <= FRAME_W'(1)) begin
        state        <= IDLE;
        frames_left  <= '0;
        phase_cnt    <= '0;
        hidden       <= 1'b0;
        flashing_out <= 1'b0;
      end else begin
        frames_left <= frames_left - FRAME_W'(1);
        if (phase_cnt == PHASE_W'(BLINK_PERIOD - 1)) begin
          phase_cnt <= '0;
          hidden    <= ~hidden;
        end else begin
          phase_cnt <= phase_cnt + PHASE_W'(1);
        end
      end
    end
  end

  assign visible_out = ~hidden;

endmodule

// File: rtl/display_layer_compositor.sv
// Two-stage priority compositor of NUM_LAYERS pixel layers with border/blank
// override. Per-layer flashing is built only when COMPOSITOR_FLASH_EN is defined.
module display_layer_compositor
  import display_pkg::*;
#(
  parameter int                     NUM_LAYERS      = 4,
  parameter int                     PIXEL_WIDTH     = 24,
  parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT_KEY = PIXEL_WIDTH'(DEFAULT_TRANSPARENT_KEY),
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR        = PIXEL_WIDTH'(DEFAULT_BG_COLOR),
  parameter logic [PIXEL_WIDTH-1:0] BORDER_COLOR    = PIXEL_WIDTH'(DEFAULT_BORDER_COLOR),
  parameter int                     FLASH_FRAMES    = 30,
  parameter int                     BLINK_PERIOD    = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_LAYERS*PIXEL_WIDTH-1:0] layer_pixels_in,
  input  logic [NUM_LAYERS-1:0]             layer_en_in,
  input  logic                              border_in,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic                              blank_in,
  input  logic                              new_frame_in,
  input  logic [NUM_LAYERS-1:0]             flash_req_in,
  output logic [PIXEL_WIDTH-1:0]            pixel_out,
  output logic                              hsync_out,
  output logic                              vsync_out,
  output logic                              blank_out,
  output logic [NUM_LAYERS-1:0]             flashing_out
);

  logic [NUM_LAYERS-1:0] flash_visible;
  logic [NUM_LAYERS-1:0] layer_visible;
  logic [PIXEL_WIDTH-1:0] sel_pixel;

`ifdef COMPOSITOR_FLASH_EN
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_flash
    layer_flash_ctrl #(
      .FLASH_FRAMES (FLASH_FRAMES),
      .BLINK_PERIOD (BLINK_PERIOD)
    ) u_flash (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .flash_req_in (flash_req_in[i]),
      .new_frame_in (new_frame_in),
      .visible_out  (flash_visible[i]),
      .flashing_out (flashing_out[i])
    );
  end
`else
  localparam int unused_flash_cfg = FLASH_FRAMES + BLINK_PERIOD;
  logic unused_flash_inputs;
  assign unused_flash_inputs = ^{flash_req_in, new_frame_in};
  assign flash_visible = '1;
  assign flashing_out  = '0;
`endif

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_vis
    assign layer_visible[i] = layer_en_in[i] && flash_visible[i] &&
        (layer_pixels_in[i*PIXEL_WIDTH +: PIXEL_WIDTH] != TRANSPARENT_KEY);
  end

  // NOTE: give every always_comb output a default first; a path that leaves it
  // unassigned would infer a latch.
  always_comb begin
    sel_pixel = BG_COLOR;
    // Walk from the lowest-priority layer upward so layer 0 overrides last.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_visible[i]) sel_pixel = layer_pixels_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  logic [PIXEL_WIDTH-1:0] s1_pixel;
  logic                   s1_border;
  logic                   s1_hsync;
  logic                   s1_vsync;
  logic                   s1_blank;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_pixel  <= '0;
      s1_border <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_blank  <= 1'b0;
    end else begin
      s1_pixel  <= sel_pixel;
      s1_border <= border_in;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      s1_blank  <= blank_in;
    end
  end

  // Blanking dominates the border, which dominates the composited layers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b0;
    end else begin
      if (s1_blank)       pixel_out <= '0;
      else if (s1_border) pixel_out <= BORDER_COLOR;
      else                pixel_out <= s1_pixel;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
      blank_out <= s1_blank;
    end
  end

endmodule
